iob_shift_sticky_pipe: RTL and testbench
========================================

// Module: iob_shift_sticky_pipe
// PURPOSE
//  Pipelined, handshaked right-shifter for FP mantissa alignment and normalisation.
//  Shifts man_i right by shift_i and reports the lost bits as sticky, optionally
//  with separate guard/round bits. Sits between the exponent-difference and the
//  adder/rounder stages of the pt-float datapath.
//  It supersedes the combinational sticky-only helper.
// PARAMETERS
//  DATA_W   32  mantissa width (>=4)
//  SHIFT_W  16  shift-amount width
//  STAGES   2   pipeline register stages, 1..clog2(DATA_W); equals latency
// PORTS
//  clk_i        in   1        clock
//  rst_i        in   1        synchronous, active-high reset
//  flush_i      in   1        sync clear of all in-flight entries
//  in_valid_i   in   1        input operand valid
//  in_ready_o   out  1        input accepted when in_valid_i & in_ready_o
//  man_i        in   DATA_W   mantissa to shift
//  shift_i      in   SHIFT_W  right-shift amount, unsigned
//  out_valid_o  out  1        result valid
//  out_ready_i  in   1        downstream accepts result
//  man_o        out  DATA_W   man_i >> shift_i
//  sticky_o     out  1        OR of dropped bits (see GRS option)
//  guard_o      out  1        only with IOB_SHIFT_STICKY_GRS_EN
//  round_o      out  1        only with IOB_SHIFT_STICKY_GRS_EN
// BEHAVIOUR
//  - Reset: all stage valids, out_valid_o, man_o, sticky_o, guard_o, round_o = 0.
//  - advance = ~out_valid_o | out_ready_i. The whole pipe moves only on advance.
//    There is no bubble collapse.
//  - in_ready_o = advance & ~flush_i. It is combinational from out_ready_i.
//  - Latency: STAGES cycles from accept to out_valid_o, when not stalled.
//  - Throughput: 1 result per cycle while out_ready_i=1.
//  - L = clog2(DATA_W). Shift bits [L-1:0] are split into STAGES contiguous groups,
//    LSB group first. Each stage shifts by its group and ORs the dropped bits
//    into the carried sticky.
//  - Overflow: if shift_i >= DATA_W, decided at input capture:
//    man_o = 0, sticky_o = |man_i.
//  - Stall (advance=0): every stage register holds, and the outputs remain stable.
//  - flush_i: all valids clear on the next edge. Data regs are don't-care.
//    flush_i has priority over a simultaneous accept and over out_ready_i.
//  - rst_i mid-operation: all in-flight entries are discarded, and outputs go
//    to their reset values.
//  - shift_i = 0: man_o = man_i and sticky_o = 0.
// CONFIGURATION
//  IOB_SHIFT_STICKY_GRS_EN defined:
//  - The datapath carries 2 extra LSBs.
//  - guard_o = bit (shift_i-1) of man_i.
//  - round_o = bit (shift_i-2) of man_i.
//  - sticky_o = OR of bits below (shift_i-2).
//  - Positions below 0 or at/above DATA_W read as 0.
//  - For shift_i >= DATA_W+2: guard_o = round_o = 0, sticky_o = |man_i.
//  IOB_SHIFT_STICKY_GRS_EN undefined:
//  - guard_o/round_o ports are absent.
//  - sticky_o = OR of all shift_i dropped bits.
// STRUCTURE
//  - iob_shift_sticky_defs.vh holds localparams:
//    L = clog2(DATA_W), per-stage group bounds, extended width DATA_W+2 (GRS).
//  - Sub-module iob_shift_sticky_stage is instantiated STAGES times. It is
//    purely combinational: group shift + sticky accumulate. Registers live
//    in the top level.
// TESTING (DATA_W=32, SHIFT_W=16, STAGES=2; GRS values in brackets)
//  - man=0xa2e513cd, sh=5 -> man_o=0x0517289e, sticky=1
//    [guard=0, round=1, sticky=1].
//  - man=0xa2e51300, sh=5 -> man_o=0x05172898, sticky=0
//    [guard=0, round=0, sticky=0].
//  - man=0xa2e513cd, sh=30 -> man_o=0x2, sticky=1.
//    sh=40 -> man_o=0, sticky=1.
//    man=0, sh=40 -> man_o=0, sticky=0.
//  - Back-to-back stream of 8 operands with out_ready_i=1:
//    results arrive on 8 consecutive cycles, 2 cycles after each accept, in order.
//  - Pipe full, out_ready_i=0 for 3 cycles: in_ready_o=0, and man_o/sticky_o
//    remain stable. Release: results drain with none lost or duplicated.
//  - flush_i and rst_i each asserted with 2 entries in flight:
//    out_valid_o=0 next cycle, no stale result ever emitted.
//    flush_i with in_valid_i=1: operand not accepted.

Source files
------------

// File: rtl/iob_shift_sticky_pipe_pkg.sv
// iob_shift_sticky_pipe_pkg: extra-LSB count and per-stage shift-group bounds (IOB_SHIFT_STICKY_GRS_EN adds guard/round bits)
package iob_shift_sticky_pipe_pkg;
`ifdef IOB_SHIFT_STICKY_GRS_EN
  localparam int XB = 2;
`else
  localparam int XB = 0;
`endif
  function automatic int grp_lo(int l, int s, int i);
    return i * l / s;
  endfunction
  function automatic int grp_hi(int l, int s, int i);
    return (i + 1) * l / s - 1;
  endfunction
endpackage

// File: rtl/iob_shift_sticky_stage.sv
// iob_shift_sticky_stage: combinational shift by one group of shift bits, ORing dropped bits into sticky
module iob_shift_sticky_stage #(
  parameter int EW = 34,
  parameter int L = 5,
  parameter int LO = 0,
  parameter int HI = 2
) (
  input  logic [EW-1:0] x,
  input  logic          s,
  input  logic [L-1:0]  sh,
  output logic [EW-1:0] x_sh,
  output logic          s_sh
);
  localparam logic [L-1:0] GM = L'((1 << (HI + 1)) - (1 << LO));
  logic [L-1:0] amt;
  always_comb begin
    amt = sh & GM;
    x_sh = x >> amt;
    s_sh = s | (|(x & ~({EW{1'b1}} << amt)));
  end
endmodule

// File: rtl/iob_shift_sticky_pipe.sv
// iob_shift_sticky_pipe: pipelined valid/ready right shifter with sticky; guard_o/round_o exist with IOB_SHIFT_STICKY_GRS_EN
module iob_shift_sticky_pipe
  import iob_shift_sticky_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SHIFT_W = 16,
  parameter int STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [DATA_W-1:0]  man_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [DATA_W-1:0]  man_o,
  output logic               sticky_o
`ifdef IOB_SHIFT_STICKY_GRS_EN
  ,
  output logic               guard_o,
  output logic               round_o
`endif
);
  localparam int L = $clog2(DATA_W);
  localparam int EW = DATA_W + XB;
  localparam int P2 = 1 << L;
  localparam int SW = SHIFT_W > 32 ? SHIFT_W : 32;
  localparam logic [EW-1:0] LO_MASK = ~({EW{1'b1}} << P2);
  logic adv;
  logic [SW-1:0] shx;
  logic ov, hi;
  logic [EW-1:0] x0;
  logic [EW-1:0] xi [STAGES];
  logic [EW-1:0] xo [STAGES];
  logic [EW-1:0] xq [STAGES];
  logic si [STAGES];
  logic so [STAGES];
  logic sq [STAGES];
  logic vq [STAGES];
  logic [L-1:0] shi [STAGES];
  logic [L-1:0] shq [STAGES];
  assign out_valid_o = vq[STAGES-1];
  assign adv = ~out_valid_o | out_ready_i;
  assign in_ready_o = adv & ~flush_i;
  always_comb begin
    shx = SW'(shift_i);
    x0 = EW'(man_i) << XB;
    ov = shx >= SW'(EW);
    hi = shx >= SW'(P2);
    xi[0] = ov ? '0 : hi ? x0 >> P2 : x0;
    si[0] = ov ? |man_i : hi && (|(x0 & LO_MASK));
    shi[0] = shift_i[L-1:0];
    for (int i = 1; i < STAGES; i++) begin
      xi[i] = xq[i-1];
      si[i] = sq[i-1];
      shi[i] = shq[i-1];
    end
  end
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    iob_shift_sticky_stage #(
      .EW(EW),
      .L(L),
      .LO(grp_lo(L, STAGES, k)),
      .HI(grp_hi(L, STAGES, k))
    ) u_st (
      .x(xi[k]),
      .s(si[k]),
      .sh(shi[k]),
      .x_sh(xo[k]),
      .s_sh(so[k])
    );
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < STAGES; i++) begin
        xq[i] <= '0;
        sq[i] <= 1'b0;
        shq[i] <= '0;
        vq[i] <= 1'b0;
      end
    end else begin
      if (adv) begin
        for (int i = 0; i < STAGES; i++) begin
          xq[i] <= xo[i];
          sq[i] <= so[i];
          shq[i] <= shi[i];
        end
      end
      vq[0] <= ~flush_i & (adv ? in_valid_i : vq[0]);
      for (int i = 1; i < STAGES; i++) vq[i] <= ~flush_i & (adv ? vq[i-1] : vq[i]);
    end
  end
  always_comb begin
    man_o = xq[STAGES-1][EW-1 -: DATA_W];
    sticky_o = sq[STAGES-1];
`ifdef IOB_SHIFT_STICKY_GRS_EN
    guard_o = xq[STAGES-1][1];
    round_o = xq[STAGES-1][0];
`endif
  end
endmodule

// File: tb/tb_iob_shift_sticky_pipe.sv
// tb_iob_shift_sticky_pipe: randomized and directed self-checking bench against a queue-based reference model
module tb_iob_shift_sticky_pipe;
  localparam int DW = 32;
  localparam int ST = 2;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic flush_i = 1'b0;
  logic in_valid_i = 1'b0;
  logic out_ready_i = 1'b0;
  logic [31:0] man_i = '0;
  logic [15:0] shift_i = '0;
  logic in_ready_o, out_valid_o, sticky_o;
  logic [31:0] man_o;
`ifdef IOB_SHIFT_STICKY_GRS_EN
  logic guard_o, round_o;
`endif
  always #5 clk = ~clk;
  iob_shift_sticky_pipe #(.DATA_W(DW), .SHIFT_W(16), .STAGES(ST)) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .in_valid_i(in_valid_i),
    .in_ready_o(in_ready_o),
    .man_i(man_i),
    .shift_i(shift_i),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .man_o(man_o),
    .sticky_o(sticky_o)
`ifdef IOB_SHIFT_STICKY_GRS_EN
    ,
    .guard_o(guard_o),
    .round_o(round_o)
`endif
  );
  typedef struct {
    logic [31:0] man;
    logic s, g, r;
    int cyc;
  } exp_t;
  typedef struct packed {
    logic [31:0] m;
    logic [15:0] sh;
    logic [31:0] mo;
    logic s, gs, g, r;
  } vec_t;
  localparam vec_t VECS [9] = '{
    '{32'ha2e513cd, 16'd5,  32'h0517289e, 1'b1, 1'b1, 1'b0, 1'b1},
    '{32'ha2e51300, 16'd5,  32'h05172898, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'ha2e513cd, 16'd30, 32'h00000002, 1'b1, 1'b1, 1'b1, 1'b0},
    '{32'ha2e513cd, 16'd40, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0},
    '{32'h00000000, 16'd40, 32'h00000000, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'h12345678, 16'd0,  32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0},
    '{32'ha2e513cd, 16'd32, 32'h00000000, 1'b1, 1'b1, 1'b1, 1'b0},
    '{32'ha2e513cd, 16'd33, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b1},
    '{32'h80000001, 16'd31, 32'h00000001, 1'b1, 1'b1, 1'b0, 1'b0}
  };
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int n_out = 0;
  bit lat_chk = 1'b0;
  exp_t q[$];
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic bitat(logic [31:0] m, int p);
    return (p >= 0 && p < DW) ? m[p] : 1'b0;
  endfunction
  function automatic exp_t model(logic [31:0] m, int n, int c);
    exp_t e;
    e.man = n >= DW ? 32'h0 : m >> n;
    e.s = 1'b0;
    e.g = 1'b0;
    e.r = 1'b0;
    e.cyc = c;
`ifdef IOB_SHIFT_STICKY_GRS_EN
    e.g = bitat(m, n - 1);
    e.r = bitat(m, n - 2);
    for (int p = 0; p < n - 2; p++) e.s |= bitat(m, p);
`else
    for (int p = 0; p < n; p++) e.s |= bitat(m, p);
`endif
    return e;
  endfunction
  always @(negedge clk) begin
    cyc++;
    if (rst_i) q.delete();
    else begin
      if (out_valid_o) begin
        check("stale", q.size() != 0, 1);
        if (q.size() != 0) begin
          check("man", man_o, q[0].man);
          check("sticky", sticky_o, q[0].s);
`ifdef IOB_SHIFT_STICKY_GRS_EN
          check("guard", guard_o, q[0].g);
          check("round", round_o, q[0].r);
`endif
          if (lat_chk && out_ready_i) check("latency", cyc - q[0].cyc, ST);
          if (out_ready_i && !flush_i) begin
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      if (flush_i) q.delete();
      else if (in_valid_i && in_ready_o) q.push_back(model(man_i, int'(shift_i), cyc));
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(logic [31:0] m, logic [15:0] sh);
    in_valid_i = 1'b1;
    man_i = m;
    shift_i = sh;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready_o) break;
    end
    check("accept", in_ready_o, 1);
    tick();
    in_valid_i = 1'b0;
  endtask
  task automatic fill_two();
    for (int i = 0; i < 2; i++) begin
      in_valid_i = 1'b1;
      man_i = $urandom;
      shift_i = 16'($urandom_range(0, 40));
      @(negedge clk);
      check("fill_ready", in_ready_o, 1);
      tick();
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n0, acc, w;
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_valid", out_valid_o, 0);
    check("rst_man", man_o, 0);
    check("rst_sticky", sticky_o, 0);
    check("rst_ready", in_ready_o, 1);
    tick();
    out_ready_i = 1'b1;
    foreach (VECS[i]) begin
      send(VECS[i].m, VECS[i].sh);
      w = 0;
      while (!out_valid_o && w < 10) begin
        @(negedge clk);
        w++;
      end
      check("d_valid", out_valid_o, 1);
      check("d_man", man_o, VECS[i].mo);
`ifdef IOB_SHIFT_STICKY_GRS_EN
      check("d_sticky", sticky_o, VECS[i].gs);
      check("d_guard", guard_o, VECS[i].g);
      check("d_round", round_o, VECS[i].r);
`else
      check("d_sticky", sticky_o, VECS[i].s);
`endif
      tick();
    end
    lat_chk = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 8; i++) begin
      in_valid_i = 1'b1;
      man_i = $urandom;
      shift_i = 16'($urandom_range(0, 40));
      @(negedge clk);
      check("s_ready", in_ready_o, 1);
      tick();
    end
    in_valid_i = 1'b0;
    repeat (ST + 3) tick();
    lat_chk = 1'b0;
    check("s_count", n_out - n0, 8);
    out_ready_i = 1'b0;
    n0 = n_out;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid_i = 1'b1;
      man_i = $urandom;
      shift_i = 16'($urandom_range(0, 40));
      @(negedge clk);
      if (!in_ready_o) break;
      acc++;
      tick();
    end
    check("fill", acc, ST);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_ready", in_ready_o, 0);
      check("stall_valid", out_valid_o, 1);
    end
    tick();
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (ST + 3) tick();
    check("drain", q.size(), 0);
    check("drain_count", n_out - n0, acc);
    fill_two();
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    @(negedge clk);
    check("fl_ready", in_ready_o, 0);
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("fl_idle", out_valid_o, 0);
    end
    tick();
    out_ready_i = 1'b0;
    fill_two();
    in_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    check("mr_valid", out_valid_o, 0);
    check("mr_man", man_o, 0);
    check("mr_sticky", sticky_o, 0);
`ifdef IOB_SHIFT_STICKY_GRS_EN
    check("mr_guard", guard_o, 0);
    check("mr_round", round_o, 0);
`endif
    tick();
    out_ready_i = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mr_idle", out_valid_o, 0);
    end
    tick();
    for (int i = 0; i < 400; i++) begin
      in_valid_i = ($urandom % 4) != 0;
      man_i = ($urandom % 4 == 0) ? ($urandom << $urandom_range(0, 31)) : $urandom;
      shift_i = ($urandom % 8 == 0) ? 16'($urandom_range(32, 70)) : 16'($urandom_range(0, 35));
      out_ready_i = ($urandom % 3) != 0;
      flush_i = $urandom_range(0, 39) == 0;
      tick();
    end
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (ST + 4) tick();
    check("final_drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
